// File: rtl/shl_seq_32.sv
// -----------------------------------------------------------------------------
// shl_seq_32 : multi-cycle 32-bit left shifter for the Mini SRC ALU.
//
// Performs SHL (logical shift left, zero fill) by a 5-bit amount, advancing
// STEP bit positions per clock in the SHIFT state. Operands are captured on
// the accepted start edge. The result and carry are held until the next
// accepted start or a clear.
//
// Optional feature macro: ROTATE_EN
//   defined   : adds the rot input; rot=1 makes the operation a rotate left
//               (the vacated low bits take the bits leaving bit 31).
//   undefined : no rot port, no mode register, no wrap path; every
//               operation is a logical shift left. Timing is identical.
//
// Parameters
//   STEP    bit positions shifted per SHIFT cycle: 1, 2, 4, 8 or 16
//
// Ports
//   clock   in   1   system clock, rising edge
//   clear   in   1   synchronous active-high reset, overrides everything
//   start   in   1   request, only looked at in IDLE
//   B       in   32  operand, captured on the accepted start edge
//   shamt   in   5   shift amount 0..31, captured with B
//   rot     in   1   1 = rotate left (only with ROTATE_EN)
//   busy    out  1   high while in SHIFT or DONE
//   done    out  1   one-cycle completion pulse
//   result  out  32  shifted value, valid from the done cycle on
//   carry   out  1   last bit shifted out of bit 31 (0 when shamt = 0)
// -----------------------------------------------------------------------------
module shl_seq_32 #(
    parameter int STEP = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
`ifdef ROTATE_EN
    input  logic        rot,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry
);

    // Reject unsupported step sizes while elaborating.
    generate
        if (!((STEP == 1) || (STEP == 2) || (STEP == 4) || (STEP == 8) || (STEP == 16))) begin : g_bad_step
            $error("shl_seq_32: STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP_W = 5'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q,  work_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  n_s;          // positions shifted this cycle: min(STEP, count)
    logic [31:0] shifted_s;    // work after this cycle's shift (or rotate)
    logic        out_bit_s;    // last bit that left bit 31 this cycle

    // The step is never larger than what remains, so count cannot underflow.
    assign n_s = (count_q < STEP_W) ? count_q : STEP_W;

`ifdef ROTATE_EN
    logic        mode_q, mode_d;
    logic [63:0] ext_s;

    // Shifting into a 64-bit word keeps the escaping bits in the upper half;
    // those are exactly the bits a rotate wraps back into the low end.
    assign ext_s     = {32'h0000_0000, work_q} << n_s;
    assign shifted_s = ext_s[31:0] | (mode_q ? ext_s[63:32] : 32'h0000_0000);
    assign out_bit_s = ext_s[32];
`else
    logic [32:0] ext_s;

    // Bit 32 of the extended word is the last bit pushed past bit 31.
    assign ext_s     = {1'b0, work_q} << n_s;
    assign shifted_s = ext_s[31:0];
    assign out_bit_s = ext_s[32];
`endif

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef ROTATE_EN
        mode_d   = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = B;
                    count_d = shamt;
`ifdef ROTATE_EN
                    mode_d  = rot;
`endif
                    carry_d = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d  = shifted_s;
                count_d = count_q - n_s;
                // A zero-length step (shamt = 0) must leave carry at 0.
                if (n_s != 5'd0) begin
                    carry_d = out_bit_s;
                end else begin
                    carry_d = carry_q;
                end
                // Last step: publish the result on the same edge DONE is entered.
                if (count_q <= STEP_W) begin
                    result_d = shifted_s;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs; clear overrides all.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            work_q   <= 32'h0000_0000;
            count_q  <= 5'd0;
            result_q <= 32'h0000_0000;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            // Status flags are decoded from the next state so they line up
            // with the state register without extra output logic.
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

`ifdef ROTATE_EN
    // Mode register for rotate versus logical shift.
    always_ff @(posedge clock) begin
        if (clear) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_shl_seq_32.sv
// -----------------------------------------------------------------------------
// Testbench for shl_seq_32: one STEP=1 instance and one STEP=8 instance,
// directed vectors with hand-computed results, carries and latencies.
// -----------------------------------------------------------------------------
module tb_shl_seq_32;

    logic        clock = 1'b0;
    logic        clear;
    logic        start1;
    logic        start8;
    logic [31:0] b;
    logic [4:0]  shamt;
`ifdef ROTATE_EN
    logic        rot;
`endif

    logic        busy1, done1, carry1;
    logic [31:0] result1;
    logic        busy8, done8, carry8;
    logic [31:0] result8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    shl_seq_32 #(.STEP(1)) u_dut1 (
        .clock  (clock),
        .clear  (clear),
        .start  (start1),
        .B      (b),
        .shamt  (shamt),
`ifdef ROTATE_EN
        .rot    (rot),
`endif
        .busy   (busy1),
        .done   (done1),
        .result (result1),
        .carry  (carry1)
    );

    shl_seq_32 #(.STEP(8)) u_dut8 (
        .clock  (clock),
        .clear  (clear),
        .start  (start8),
        .B      (b),
        .shamt  (shamt),
`ifdef ROTATE_EN
        .rot    (rot),
`endif
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .carry  (carry8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One operation: start, check busy, wait for done, check result/carry/latency,
    // then check that done was a single-cycle pulse. With poke set, a second
    // start with different operands is pulsed while the first op is running.
    task automatic run_op(input string tag, input bit use8, input logic [31:0] bv,
                          input logic [4:0] sv, input logic [31:0] exp_res,
                          input logic exp_c, input int exp_lat, input bit poke);
        int lat;
        lat = 0;
        @(negedge clock);
        b     = bv;
        shamt = sv;
        if (use8) start8 = 1'b1; else start1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start1 = 1'b0;
        start8 = 1'b0;
        b      = 32'h5A5A_5A5A;
        shamt  = 5'd17;
        check_val({tag, "_busy"}, 32'(use8 ? busy8 : busy1), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if ((use8 ? done8 : done1) == 1'b1) begin
                lat = k;
                break;
            end
            if (poke && k == 1) begin
                b = 32'hFFFF_FFFF; shamt = 5'd3;
                if (use8) start8 = 1'b1; else start1 = 1'b1;
            end
            if (poke && k == 2) begin
                start1 = 1'b0;
                start8 = 1'b0;
            end
        end
        check_val({tag, "_lat"},    32'(lat), 32'(exp_lat));
        check_val({tag, "_result"}, use8 ? result8 : result1, exp_res);
        check_val({tag, "_carry"},  32'(use8 ? carry8 : carry1), 32'(exp_c));
        @(posedge clock);
        @(negedge clock);
        check_val({tag, "_done_off"}, 32'(use8 ? done8 : done1), 32'd0);
        check_val({tag, "_idle"},     32'(use8 ? busy8 : busy1), 32'd0);
    endtask

    initial begin
        int seen;
        clear  = 1'b1;
        start1 = 1'b0;
        start8 = 1'b0;
        b      = 32'h0000_0000;
        shamt  = 5'd0;
`ifdef ROTATE_EN
        rot    = 1'b0;
`endif
        // Reset held for two edges.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_busy",   32'(busy1),  32'd0);
        check_val("rst_done",   32'(done1),  32'd0);
        check_val("rst_result", result1,     32'h0000_0000);
        check_val("rst_carry",  32'(carry1), 32'd0);
        check_val("rst8_busy",  32'(busy8),  32'd0);
        clear = 1'b0;

        // STEP=1 vectors.
        run_op("t1_shl31",  1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 31, 1'b0);
        run_op("t2_shl1",   1'b0, 32'hC000_0003, 5'd1,  32'h8000_0006, 1'b1, 1,  1'b0);
        run_op("t3_shl0",   1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1,  1'b0);
        run_op("t3_ignore", 1'b0, 32'h0000_0001, 5'd5,  32'h0000_0020, 1'b0, 5,  1'b1);
        run_op("t3_after",  1'b0, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b1, 4,  1'b0);
        run_op("ones31",    1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1, 31, 1'b0);

        // Clear in the middle of a 20-bit shift, at edge 7.
        @(negedge clock);
        b = 32'h0000_0001; shamt = 5'd20; start1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start1 = 1'b0;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
        end
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        check_val("t4_busy",   32'(busy1),  32'd0);
        check_val("t4_done",   32'(done1),  32'd0);
        check_val("t4_result", result1,     32'h0000_0000);
        check_val("t4_carry",  32'(carry1), 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clock);
            @(negedge clock);
            if (done1 == 1'b1 || busy1 == 1'b1) seen++;
        end
        check_val("t4_no_done", 32'(seen), 32'd0);
        run_op("t4_fresh", 1'b0, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 2, 1'b0);

        // Start held high: one IDLE cycle between back-to-back operations.
        @(negedge clock);
        b = 32'h0000_0001; shamt = 5'd2; start1 = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("hold_done1",   32'(done1), 32'd1);
        check_val("hold_result1", result1,    32'h0000_0004);
        b = 32'h0000_0003;
        @(posedge clock);
        @(negedge clock);
        check_val("hold_gap", 32'(busy1), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check_val("hold_restart", 32'(busy1), 32'd1);
        start1 = 1'b0;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done1 == 1'b1) begin
                seen = k;
                break;
            end
        end
        check_val("hold_lat2",    32'(seen), 32'd2);
        check_val("hold_result2", result1,   32'h0000_000C);

        // Logical shift on the operands that the rotate vectors use.
        run_op("t5_shl", 1'b0, 32'h8000_0001, 5'd4, 32'h0000_0010, 1'b0, 4, 1'b0);
`ifdef ROTATE_EN
        rot = 1'b1;
        run_op("t5_rol4", 1'b0, 32'h8000_0001, 5'd4, 32'h0000_0018, 1'b0, 4, 1'b0);
        run_op("t5_rol1", 1'b0, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b1, 1, 1'b0);
        run_op("t5_rol8", 1'b1, 32'h1234_5678, 5'd12, 32'h4567_8123, 1'b1, 2, 1'b0);
        rot = 1'b0;
`endif

        // STEP=8 vectors.
        run_op("t6_s8_20", 1'b1, 32'h0000_00FF, 5'd20, 32'h0FF0_0000, 1'b0, 3, 1'b0);
        run_op("s8_31",    1'b1, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 4, 1'b0);
        run_op("s8_8",     1'b1, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00, 1'b1, 1, 1'b0);
        run_op("s8_0",     1'b1, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
